// File: rtl/block_ram_bist_master.sv
// March C- BIST master for a single-port block RAM (backgrounds all-zeros / all-ones).
// Optional macro BIST_STOP_ON_FAIL_EN: end the test at the first mismatch.
module block_ram_bist_master #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  START,
    output logic                  READ,
    output logic                  WRITE,
    output logic [ADDR_WIDTH-1:0] ADDR,
    output logic [DATA_WIDTH-1:0] DATAI,
    input  logic [DATA_WIDTH-1:0] DATAO,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  FAIL,
    output logic [ADDR_WIDTH-1:0] FAIL_ADDR,
    output logic [DATA_WIDTH-1:0] FAIL_DATA
);

    typedef enum logic [2:0] {IDLE, WR, RD, CMP, FIN} state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    state_t                  state;
    logic [2:0]              elem;
    logic                    down;
    logic                    next_down;
    logic                    last_addr;
    logic [ADDR_WIDTH-1:0]   next_addr;
    logic [DATA_WIDTH-1:0]   exp_data;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic                    mismatch;
    logic                    stop_now;
    logic                    finish;

    // Element 0..5 selects direction, expected read data and write data.
    always_comb begin
        down      = (elem == 3'd3) || (elem == 3'd4);
        next_down = (elem == 3'd2) || (elem == 3'd3);
        last_addr = down ? (ADDR == '0) : (ADDR == '1);
        next_addr = down ? (ADDR - ADDR_ONE) : (ADDR + ADDR_ONE);
        exp_data  = ((elem == 3'd2) || (elem == 3'd4)) ? '1 : '0;
        wr_data   = ((elem == 3'd1) || (elem == 3'd3)) ? '1 : '0;
        mismatch  = (DATAO != exp_data);
`ifdef BIST_STOP_ON_FAIL_EN
        stop_now  = mismatch;
`else
        stop_now  = 1'b0;
`endif
        finish    = stop_now || ((elem == 3'd5) && last_addr);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            elem      <= '0;
            READ      <= 1'b0;
            WRITE     <= 1'b0;
            ADDR      <= '0;
            DATAI     <= '0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            FAIL      <= 1'b0;
            FAIL_ADDR <= '0;
            FAIL_DATA <= '0;
        end else begin
            case (state)
                IDLE: begin
                    READ  <= 1'b0;
                    WRITE <= 1'b0;
                    ADDR  <= '0;
                    DATAI <= '0;
                    if (START) begin
                        state     <= WR;
                        elem      <= '0;
                        WRITE     <= 1'b1;
                        BUSY      <= 1'b1;
                        DONE      <= 1'b0;
                        FAIL      <= 1'b0;
                        FAIL_ADDR <= '0;
                        FAIL_DATA <= '0;
                    end
                end
                WR: begin
                    WRITE <= 1'b0;
                    if (last_addr) begin
                        // Every element after M0 begins with a read.
                        elem  <= elem + 3'd1;
                        ADDR  <= next_down ? '1 : '0;
                        state <= RD;
                        READ  <= 1'b1;
                    end else begin
                        ADDR <= next_addr;
                        if (elem == 3'd0) begin
                            state <= WR;
                            WRITE <= 1'b1;
                        end else begin
                            state <= RD;
                            READ  <= 1'b1;
                        end
                    end
                end
                RD: begin
                    READ  <= 1'b0;
                    state <= CMP;
                end
                CMP: begin
                    if (mismatch) begin
                        FAIL <= 1'b1;
                        if (!FAIL) begin
                            FAIL_ADDR <= ADDR;
                            FAIL_DATA <= DATAO;
                        end
                    end
                    if (finish) begin
                        state <= FIN;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                        ADDR  <= '0;
                        DATAI <= '0;
                    end else if (elem == 3'd5) begin
                        ADDR  <= next_addr;
                        state <= RD;
                        READ  <= 1'b1;
                    end else begin
                        state <= WR;
                        WRITE <= 1'b1;
                        DATAI <= wr_data;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_block_ram_bist_master.sv
// Scoreboard bench for block_ram_bist_master (ADDR_WIDTH=4, DATA_WIDTH=8) with a 1-cycle RAM model.
module tb_block_ram_bist_master;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       START = 1'b0;
    logic       READ, WRITE, BUSY, DONE, FAIL;
    logic [3:0] ADDR, FAIL_ADDR;
    logic [7:0] DATAI, DATAO, FAIL_DATA;

    logic [7:0] mem [16];
    logic       fault_en = 1'b0;

    int tests = 0;
    int fails = 0;
    int overlap = 0;

    typedef struct {
        int         busy;
        logic       fail;
        logic [3:0] fa;
        logic [7:0] fd;
    } exp_t;
    exp_t sb[$];

    block_ram_bist_master #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
        .CLK(CLK), .RESET(RESET), .START(START),
        .READ(READ), .WRITE(WRITE), .ADDR(ADDR), .DATAI(DATAI), .DATAO(DATAO),
        .BUSY(BUSY), .DONE(DONE), .FAIL(FAIL), .FAIL_ADDR(FAIL_ADDR), .FAIL_DATA(FAIL_DATA)
    );

    always #5 CLK = ~CLK;

    // RAM with optional bit0 stuck-at-1 at address 0x5.
    initial for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    initial DATAO = 8'h00;
    always @(posedge CLK) begin
        if (WRITE) mem[ADDR] <= DATAI;
        if (READ) DATAO <= (fault_en && ADDR == 4'h5) ? (mem[ADDR] | 8'h01) : mem[ADDR];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: counts BUSY cycles per run and checks result registers when DONE rises.
    logic busy_prev = 1'b0;
    logic done_prev = 1'b0;
    int   busy_cnt = 0;
    always @(negedge CLK) begin
        exp_t e;
        if (READ === 1'b1 && WRITE === 1'b1) overlap++;
        if (BUSY === 1'b1 && !busy_prev) busy_cnt = 0;
        if (BUSY === 1'b1) busy_cnt++;
        if (DONE === 1'b1 && !done_prev) begin
            check("sb_has_entry", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("busy_cycles", busy_cnt, e.busy);
                check("fail_flag", FAIL, e.fail);
                check("fail_addr", FAIL_ADDR, e.fa);
                check("fail_data", FAIL_DATA, e.fd);
            end
        end
        busy_prev = (BUSY === 1'b1);
        done_prev = (DONE === 1'b1);
    end

    function automatic logic [31:0] all_out();
        return {READ, WRITE, ADDR, DATAI, BUSY, DONE, FAIL, FAIL_ADDR, FAIL_DATA};
    endfunction

    // k counts cycles after the START edge; k=1 is the first M0 write.
    task automatic run_test(input int pulse1, input int pulse2, input int rst_at, output int done_k);
        done_k = -1;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        for (int k = 1; k <= 400; k++) begin
            if (k == 1) begin
                check("first_write", WRITE, 1);
                check("first_addr", ADDR, 4'h0);
                check("first_datai", DATAI, 8'h00);
                check("first_busy", BUSY, 1);
            end
            if (k == 19) check("m1_first_write", {WRITE, ADDR, DATAI}, {1'b1, 4'h0, 8'hFF});
            if (k == 112) check("m2_last_write", {WRITE, ADDR, DATAI}, {1'b1, 4'hF, 8'h00});
            if (k == 113) check("m3_first_read", {READ, WRITE, ADDR}, {1'b1, 1'b0, 4'hF});
            if (DONE === 1'b1) begin
                done_k = k;
                check("fin_outputs", {READ, WRITE, ADDR, DATAI, BUSY}, '0);
                break;
            end
            if (k == rst_at) begin
                RESET = 1'b1;
                @(negedge CLK);
                check("mid_reset_zero", all_out(), '0);
                RESET = 1'b0;
                done_k = 0;
                break;
            end
            START = (k == pulse1) || (k == pulse2);
            @(negedge CLK);
        end
        START = 1'b0;
        if (done_k < 0) check("done_timeout", 0, 1);
    endtask

    initial begin
        int dk;
        int bus_after;
        repeat (3) @(negedge CLK);
        check("reset_outputs", all_out(), '0);
        START = 1'b1;
        @(negedge CLK);
        check("reset_beats_start", BUSY, 0);
        START = 1'b0;
        RESET = 1'b0;
        repeat (3) @(negedge CLK);
        check("idle_no_start", {BUSY, DONE}, 2'b00);

        // Fault-free run
        sb.push_back('{busy: 240, fail: 1'b0, fa: 4'h0, fd: 8'h00});
        run_test(-1, -1, -1, dk);
        check("done_cycle_clean", dk, 241);
        @(negedge CLK);
        check("done_sticky", {DONE, BUSY}, 2'b10);

        // Stuck-at fault at 0x5
        fault_en = 1'b1;
`ifdef BIST_STOP_ON_FAIL_EN
        sb.push_back('{busy: 33, fail: 1'b1, fa: 4'h5, fd: 8'h01});
        run_test(-1, -1, -1, dk);
        check("done_cycle_fault", dk + 1, 35);  // START's own cycle counted as cycle 1
        bus_after = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            if (READ || WRITE) bus_after++;
        end
        check("no_bus_after_stop", bus_after, 0);
`else
        sb.push_back('{busy: 240, fail: 1'b1, fa: 4'h5, fd: 8'h01});
        run_test(-1, -1, -1, dk);
        check("done_cycle_fault", dk, 241);
`endif
        fault_en = 1'b0;
        @(negedge CLK);

        // START re-pulsed mid-test
        sb.push_back('{busy: 240, fail: 1'b0, fa: 4'h0, fd: 8'h00});
        run_test(10, 100, -1, dk);
        check("done_cycle_repulse", dk, 241);
        @(negedge CLK);

        // Reset mid-test, then a fresh run
        run_test(-1, -1, 120, dk);
        @(negedge CLK);
        sb.push_back('{busy: 240, fail: 1'b0, fa: 4'h0, fd: 8'h00});
        run_test(-1, -1, -1, dk);
        check("done_cycle_after_reset", dk, 241);

        repeat (3) @(negedge CLK);
        check("sb_drained", sb.size(), 0);
        check("read_write_exclusive", overlap, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
